// File: rtl/signal_extend_mc.sv
// Multi-channel pulse/valid extender: stretches each 1-cycle i_vld strobe into an
// L-cycle o_vld window holding the captured payload. Optional drop counter: SIGNAL_EXTEND_MC_DROP_CNT_EN.
module signal_extend_mc #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned RETRIG = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [CH_NUM-1:0]          i_vld,
    input  logic [CH_NUM*DATA_W-1:0]   i_data,
    input  logic [LEN_W-1:0]           i_ext_len,
    output logic [CH_NUM-1:0]          o_vld,
    output logic [CH_NUM*DATA_W-1:0]   o_data,
    output logic [CH_NUM-1:0]          o_done,
    output logic                       o_any_vld
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
    ,
    output logic [15:0]                o_drop_cnt
`endif
);

    localparam int unsigned DW = CH_NUM * DATA_W;

    logic [CH_NUM-1:0]             r_vld;
    logic [CH_NUM-1:0][LEN_W-1:0]  r_cnt;
    logic [DW-1:0]                 r_data;
    logic [CH_NUM-1:0]             r_done;
    logic                          r_any_vld;

    logic [CH_NUM-1:0]             w_vld_nxt;
    logic [CH_NUM-1:0][LEN_W-1:0]  w_cnt_nxt;
    logic [DW-1:0]                 w_data_nxt;
    logic [CH_NUM-1:0]             w_done_nxt;
    logic [CH_NUM-1:0]             w_busy;
    logic [CH_NUM-1:0]             w_acc;
    logic [LEN_W-1:0]              w_len_m1;

    // A zero length behaves like a one-cycle window.
    assign w_len_m1 = (i_ext_len == '0) ? '0 : i_ext_len - LEN_W'(1);

    always_comb begin
        w_vld_nxt  = '0;
        w_cnt_nxt  = '0;
        w_data_nxt = '0;
        w_done_nxt = '0;
        w_busy     = '0;
        w_acc      = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            // Busy only before the last window cycle; a trigger on the last cycle chains seamlessly.
            w_busy[c] = r_vld[c] && (r_cnt[c] != '0);
            w_acc[c]  = i_vld[c] && (!w_busy[c] || (RETRIG != 0));
            if (w_acc[c]) begin
                w_vld_nxt[c]                  = 1'b1;
                w_cnt_nxt[c]                  = w_len_m1;
                w_data_nxt[c*DATA_W +: DATA_W] = i_data[c*DATA_W +: DATA_W];
            end else if (w_busy[c]) begin
                w_vld_nxt[c]                  = 1'b1;
                w_cnt_nxt[c]                  = r_cnt[c] - LEN_W'(1);
                w_data_nxt[c*DATA_W +: DATA_W] = r_data[c*DATA_W +: DATA_W];
            end
            w_done_nxt[c] = w_vld_nxt[c] && (w_cnt_nxt[c] == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld     <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_done    <= '0;
            r_any_vld <= 1'b0;
        end else begin
            r_vld     <= w_vld_nxt;
            r_cnt     <= w_cnt_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_any_vld <= |w_vld_nxt;
        end
    end

    assign o_vld     = r_vld;
    assign o_data    = r_data;
    assign o_done    = r_done;
    assign o_any_vld = r_any_vld;

`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic [16:0] w_drop_sum;
    logic [15:0] w_drop_nxt;

    // A busy-window trigger is lost either way: ignored (RETRIG=0) or aborting the window (RETRIG=1).
    always_comb begin
        w_drop_sum = 17'(r_drop_cnt);
        for (int c = 0; c < CH_NUM; c++) begin
            w_drop_sum = w_drop_sum + 17'(i_vld[c] && w_busy[c]);
        end
        w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_signal_extend_mc.sv
// Directed bench for signal_extend_mc: one RETRIG=1 and one RETRIG=0 instance on shared stimulus.
module tb_signal_extend_mc;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_vld;
    logic [31:0] i_data;
    logic [3:0]  i_ext_len;

    logic [3:0]  vld_a, vld_b, done_a, done_b;
    logic [31:0] data_a, data_b;
    logic        any_a, any_b;
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
    logic [15:0] drop_a, drop_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    signal_extend_mc #(.CH_NUM(4), .DATA_W(8), .LEN_W(4), .RETRIG(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(i_vld), .i_data(i_data), .i_ext_len(i_ext_len),
        .o_vld(vld_a), .o_data(data_a), .o_done(done_a), .o_any_vld(any_a)
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
        , .o_drop_cnt(drop_a)
`endif
    );

    signal_extend_mc #(.CH_NUM(4), .DATA_W(8), .LEN_W(4), .RETRIG(0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(i_vld), .i_data(i_data), .i_ext_len(i_ext_len),
        .o_vld(vld_b), .o_data(data_b), .o_done(done_b), .o_any_vld(any_b)
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
        , .o_drop_cnt(drop_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge, strobes drop back to 0.
    task automatic tick();
        @(posedge clk);
        #1;
        i_vld = '0;
    endtask

    task automatic chk_ch(input string tag, input int which, input int ch,
                          input logic v, input logic [7:0] d, input logic dn);
        logic [3:0]  vv, dd;
        logic [31:0] da;
        vv = (which == 0) ? vld_a  : vld_b;
        dd = (which == 0) ? done_a : done_b;
        da = (which == 0) ? data_a : data_b;
        check_eq($sformatf("%s_%s_ch%0d_vld",  tag, which == 0 ? "a" : "b", ch), 32'(vv[ch]), 32'(v));
        check_eq($sformatf("%s_%s_ch%0d_data", tag, which == 0 ? "a" : "b", ch), 32'(da[ch*8 +: 8]), 32'(d));
        check_eq($sformatf("%s_%s_ch%0d_done", tag, which == 0 ? "a" : "b", ch), 32'(dd[ch]), 32'(dn));
    endtask

    task automatic chk_all_zero(input string tag);
        check_eq({tag, "_vld_a"},  32'(vld_a),  32'h0);
        check_eq({tag, "_vld_b"},  32'(vld_b),  32'h0);
        check_eq({tag, "_data_a"}, data_a,      32'h0);
        check_eq({tag, "_data_b"}, data_b,      32'h0);
        check_eq({tag, "_done_a"}, 32'(done_a), 32'h0);
        check_eq({tag, "_done_b"}, 32'(done_b), 32'h0);
        check_eq({tag, "_any_a"},  32'(any_a),  32'h0);
        check_eq({tag, "_any_b"},  32'(any_b),  32'h0);
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
        check_eq({tag, "_drop_a"}, 32'(drop_a), 32'h0);
        check_eq({tag, "_drop_b"}, 32'(drop_b), 32'h0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_vld = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // L=5 window on ch0 carrying 8'hA5.
    task automatic run_t1(input string tag);
        i_ext_len = 4'd5;
        i_data    = 32'h0000_00A5;
        i_vld     = 4'b0001;
        for (int t = 1; t <= 6; t++) begin
            tick();
            for (int w = 0; w < 2; w++)
                chk_ch($sformatf("%s_t%0d", tag, t), w, 0, t <= 5, (t <= 5) ? 8'hA5 : 8'h00, t == 5);
            check_eq($sformatf("%s_t%0d_any_a", tag, t), 32'(any_a), 32'(t <= 5));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        i_vld     = '0;
        i_data    = '0;
        i_ext_len = '0;
        #1;
        chk_all_zero("reset");
        do_reset();
        chk_all_zero("post_reset");

        run_t1("t1");

        // Length 0 and 1 both give a single-cycle window with done in that cycle.
        for (int l = 0; l <= 1; l++) begin
            i_ext_len = 4'(l);
            i_data    = 32'h0000_003C;
            i_vld     = 4'b0001;
            tick();
            chk_ch($sformatf("t2_len%0d_c1", l), 0, 0, 1'b1, 8'h3C, 1'b1);
            tick();
            chk_ch($sformatf("t2_len%0d_c2", l), 0, 0, 1'b0, 8'h00, 1'b0);
        end

        // Maximum length: 15 cycles.
        i_ext_len = 4'd15;
        i_data    = 32'h0000_0077;
        i_vld     = 4'b0001;
        for (int t = 1; t <= 16; t++) begin
            tick();
            chk_ch($sformatf("t2_len15_t%0d", t), 1, 0, t <= 15, (t <= 15) ? 8'h77 : 8'h00, t == 15);
        end

        // Busy retrigger on ch1 at T+2: A restarts, B ignores.
        do_reset();
        i_ext_len = 4'd4;
        i_data    = 32'h0000_1100;
        i_vld     = 4'b0010;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk_ch($sformatf("t3_t%0d", t), 0, 1, t <= 6,
                   (t <= 2) ? 8'h11 : ((t <= 6) ? 8'h22 : 8'h00), t == 6);
            chk_ch($sformatf("t4_t%0d", t), 1, 1, t <= 4, (t <= 4) ? 8'h11 : 8'h00, t == 4);
            if (t == 2) begin
                i_data = 32'h0000_2200;
                i_vld  = 4'b0010;
            end
        end
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
        check_eq("t3_drop_a", 32'(drop_a), 32'd1);
        check_eq("t4_drop_b", 32'(drop_b), 32'd1);
`endif

        // Trigger on the last window cycle chains two windows with no gap.
        do_reset();
        i_ext_len = 4'd4;
        i_data    = 32'h0000_1100;
        i_vld     = 4'b0010;
        for (int t = 1; t <= 9; t++) begin
            tick();
            for (int w = 0; w < 2; w++)
                chk_ch($sformatf("t4b_t%0d", t), w, 1, t <= 8,
                       (t <= 4) ? 8'h11 : ((t <= 8) ? 8'h22 : 8'h00), (t == 4) || (t == 8));
            if (t == 4) begin
                i_data = 32'h0000_2200;
                i_vld  = 4'b0010;
            end
        end
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
        check_eq("t4b_drop_a", 32'(drop_a), 32'd0);
        check_eq("t4b_drop_b", 32'(drop_b), 32'd0);
`endif

        // All channels at T with L=3, ch2 retriggered at T+1.
        do_reset();
        i_ext_len = 4'd3;
        i_data    = 32'h1312_1110;
        i_vld     = 4'b1111;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check_eq($sformatf("t5_t%0d_any_a", t), 32'(any_a), 32'(t <= 4));
            check_eq($sformatf("t5_t%0d_any_b", t), 32'(any_b), 32'(t <= 3));
            chk_ch($sformatf("t5_t%0d", t), 0, 0, t <= 3, (t <= 3) ? 8'h10 : 8'h00, t == 3);
            chk_ch($sformatf("t5_t%0d", t), 0, 3, t <= 3, (t <= 3) ? 8'h13 : 8'h00, t == 3);
            chk_ch($sformatf("t5_t%0d", t), 0, 2, t <= 4,
                   (t == 1) ? 8'h12 : ((t <= 4) ? 8'h99 : 8'h00), t == 4);
            chk_ch($sformatf("t5_t%0d", t), 1, 2, t <= 3, (t <= 3) ? 8'h12 : 8'h00, t == 3);
            if (t == 1) begin
                i_data = 32'h0099_0000;
                i_vld  = 4'b0100;
            end
        end
`ifdef SIGNAL_EXTEND_MC_DROP_CNT_EN
        check_eq("t5_drop_a", 32'(drop_a), 32'd1);
        check_eq("t5_drop_b", 32'(drop_b), 32'd1);
`endif

        // Asynchronous reset in the middle of a 10-cycle window.
        do_reset();
        i_ext_len = 4'd10;
        i_data    = 32'h0000_00EE;
        i_vld     = 4'b0001;
        tick();
        tick();
        chk_ch("t6_pre", 0, 0, 1'b1, 8'hEE, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        repeat (3) begin
            tick();
            chk_all_zero("t6_held");
        end
        rst_n = 1'b1;
        tick();
        chk_all_zero("t6_release");
        run_t1("t6_t1");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
